// File: rtl/unary_pkg.sv
// Shared constants for the serial unary adder: mode encoding and default width.
package unary_pkg;

  // Mode select values carried on read_or_write.
  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  // Default accumulator width; largest representable sum is 2**CNT_W - 1.
  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/unary_sat_counter.sv
// Accumulator for the unary adder: counts up by 0, 1 or 2 with saturation
// at the all-ones value, counts down by 1 with a floor at zero.
module unary_sat_counter #(
  parameter int CNT_W = unary_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic [1:0]       inc,
  input  logic             down,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // One extra bit so a +2 step from near MAX is seen rather than wrapped.
  logic [CNT_W:0] sum;

  // Widened sum and saturation detect for the current up step.
  always_comb begin
    sum     = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    ovf     = up && (sum > {1'b0, MAX});
    nonzero = (cnt != '0);
  end

  // Count register: reset, saturating add, or floored decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (up) begin
      cnt <= ovf ? MAX : sum[CNT_W-1:0];
    end else if (down && nonzero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/unary_add_1_4_8.sv
// Serial unary adder: accumulates the 1s of streams A and B in read mode,
// replays the total as a run of 1s on dout in write mode. C is a sticky
// overflow flag. rst_n is an active-high synchronous reset despite its name.
module unary_add_1_4_8
  import unary_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic en,
  input  logic read_or_write,
  output logic dout,
  output logic C
);

  mode_e            mode;
  logic             up;
  logic             down;
  logic [1:0]       inc;
  logic [CNT_W-1:0] cnt;
  logic             nonzero;
  logic             ovf;

  // Mode decode; en=0 blocks both directions so the count holds.
  always_comb begin
    mode = mode_e'(read_or_write);
    up   = en && (mode == MODE_READ);
    down = en && (mode == MODE_WRITE);
    inc  = {1'b0, A} + {1'b0, B};
  end

  unary_sat_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst_n),
    .up      (up),
    .inc     (inc),
    .down    (down),
    .cnt     (cnt),
    .nonzero (nonzero),
    .ovf     (ovf)
  );

  // Output stream: a 1 for each count drained in write mode, else 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      dout <= 1'b0;
    end else begin
      dout <= down && nonzero;
    end
  end

  // Sticky overflow: set on any saturating add, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      C <= 1'b0;
    end else if (ovf) begin
      C <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unary_add_1_4_8.sv
// Directed bench for the serial unary adder with a behavioural reference
// model checked every cycle, plus literal expectations per scenario.
module tb_unary_add_1_4_8;

  localparam int MAX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic en = 1'b0;
  logic rw = 1'b0;
  logic dout;
  logic c_flag;

  int checks = 0;
  int errors = 0;
  bit check_on = 1'b0;

  // Reference model state (plain integers).
  int  m_cnt = 0;
  bit  m_dout = 1'b0;
  bit  m_c = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  unary_add_1_4_8 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (a),
    .B             (b),
    .en            (en),
    .read_or_write (rw),
    .dout          (dout),
    .C             (c_flag)
  );

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    if (rst_n) begin
      m_cnt  = 0;
      m_dout = 1'b0;
      m_c    = 1'b0;
    end else if (!en) begin
      m_dout = 1'b0;
    end else if (!rw) begin
      m_dout = 1'b0;
      if (m_cnt + int'(a) + int'(b) > MAX) begin
        m_cnt = MAX;
        m_c   = 1'b1;
      end else begin
        m_cnt = m_cnt + int'(a) + int'(b);
      end
    end else if (m_cnt > 0) begin
      m_dout = 1'b1;
      m_cnt  = m_cnt - 1;
    end else begin
      m_dout = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_on) begin
      checks++;
      if (dout !== m_dout) begin
        errors++;
        $display("FAIL model_dout t=%0t actual=%b required=%b", $time, dout, m_dout);
      end
      checks++;
      if (c_flag !== m_c) begin
        errors++;
        $display("FAIL model_c t=%0t actual=%b required=%b", $time, c_flag, m_c);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit r, input bit ai, input bit bi, input bit e, input bit w);
    rst_n = r; a = ai; b = bi; en = e; rw = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Write for n enabled cycles; count ones and check they form one run
  // starting on the first write edge when any ones are present.
  task automatic write_n(input int n, output int ones, output bit run_ok);
    int first = -1;
    int last = -1;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (dout === 1'b1) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    end
    run_ok = (ones == 0) || (first == 0 && last - first + 1 == ones);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic read_n(input int n, input bit ai, input bit bi);
    for (int i = 0; i < n; i++) step(1'b0, ai, bi, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  ones;
    bit  run_ok;
    logic [7:0] pat_a;
    logic [7:0] pat_b;

    // Reset held two edges with A=B=1, en=1.
    do_reset(2);
    check_on = 1'b1;
    check_lit("reset_dout", int'(dout), 0);
    check_lit("reset_c", int'(c_flag), 0);
    write_n(5, ones, run_ok);
    check_lit("reset_write_ones", ones, 0);

    // Basic sum: 10 cycles of A=B=1 -> 20 ones.
    do_reset(1);
    read_n(10, 1'b1, 1'b1);
    write_n(45, ones, run_ok);
    check_lit("basic_ones", ones, 20);
    check_lit("basic_run", int'(run_ok), 1);
    check_lit("basic_c", int'(c_flag), 0);

    // Mixed streams: A has 3 ones, B has 5, two cycles overlap -> 8 ones.
    do_reset(1);
    pat_a = 8'b0000_0111;
    pat_b = 8'b0011_1110;
    for (int i = 0; i < 8; i++) read_n(1, pat_a[i], pat_b[i]);
    write_n(12, ones, run_ok);
    check_lit("mixed_ones", ones, 8);
    check_lit("mixed_run", int'(run_ok), 1);

    // Enable gating: 4 + (paused 5) + 2 read cycles -> 12 ones.
    do_reset(1);
    read_n(4, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check_lit("gate_dout_paused", int'(dout), 0);
    end
    read_n(2, 1'b1, 1'b1);
    write_n(5, ones, run_ok);
    check_lit("gate_first_ones", ones, 5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_lit("gate_dout_stalled", int'(dout), 0);
    end
    write_n(20, ones, run_ok);
    check_lit("gate_rest_ones", ones, 7);

    // Saturation: 2 per cycle reaches 254 after 127 cycles, exceeds on 128th.
    do_reset(1);
    read_n(127, 1'b1, 1'b1);
    check_lit("sat_c_before", int'(c_flag), 0);
    read_n(1, 1'b1, 1'b1);
    check_lit("sat_c_edge", int'(c_flag), 1);
    read_n(2, 1'b1, 1'b1);
    write_n(300, ones, run_ok);
    check_lit("sat_ones", ones, 255);
    check_lit("sat_run", int'(run_ok), 1);
    check_lit("sat_c_sticky", int'(c_flag), 1);
    read_n(3, 1'b1, 1'b0);
    check_lit("sat_c_after_read", int'(c_flag), 1);

    // Reset mid-write: 20 accumulated, 5 drained, then reset.
    do_reset(1);
    read_n(10, 1'b1, 1'b1);
    write_n(5, ones, run_ok);
    check_lit("midw_ones", ones, 5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_lit("midw_reset_dout", int'(dout), 0);
    check_lit("midw_reset_c", int'(c_flag), 0);
    write_n(10, ones, run_ok);
    check_lit("midw_after_ones", ones, 0);

    // Partial drain keeps the remainder: 3 - 2 + 4 = 5.
    do_reset(1);
    read_n(3, 1'b1, 1'b0);
    write_n(2, ones, run_ok);
    check_lit("partial_first", ones, 2);
    read_n(2, 1'b1, 1'b1);
    write_n(10, ones, run_ok);
    check_lit("partial_rest", ones, 5);

    check_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
